// File: rtl/thr_scan_pkg.sv
// Shared opcodes, frame header and FSM state encoding for the threshold-scan counter.
package thr_scan_pkg;

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_ABORT = 8'h41;
  localparam logic [7:0] CMD_GATE  = 8'h47;
  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_GATE = 3'd1,
    ST_ARM       = 3'd2,
    ST_COUNT     = 3'd3,
    ST_LATCH     = 3'd4,
    ST_SEND      = 3'd5,
    ST_WAIT_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/thr_edge_sync.sv
// Two-flop synchronizer for one discriminator input plus a one-cycle rising-edge pulse.
module thr_edge_sync (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Thr,
  output logic o_Pulse
);

  logic [2:0] sync_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], i_Thr};
  end

  // Pulse is combinational so the counter sees it on the third clock after the edge.
  assign o_Pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/thr_scan_multi.sv
// Gated multi-channel edge counter: command-driven scan, latched results, byte-wise frame out.
//
// state        | meaning
// IDLE         | waiting for 'S' (scan) or 'G' (gate load)
// LOAD_GATE    | shifting in gate length bytes, MSB first
// ARM          | clear live counters, load gate down-counter
// COUNT        | count edge pulses until gate timer hits terminal count
// LATCH        | copy live counters to latched registers
// SEND         | present current frame byte with o_Tx_DV
// WAIT_DONE    | wait for transmitter to finish the byte
module thr_scan_multi
  import thr_scan_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 32,
  parameter int GATE_W       = 32,
  parameter int DEFAULT_GATE = 50_000_000,
  localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic [N_CH-1:0]   i_Thr,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Done,
  input  logic [SEL_W-1:0]  i_Disp_Sel,
  output logic [CNT_W-1:0]  o_Disp_Cnt,
  output logic              o_Busy,
  output logic              o_Cnt_Valid
);

  localparam int NB   = CNT_W / 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int GB   = GATE_W / 8;
  localparam int GB_W = (GB > 1) ? $clog2(GB) : 1;

  state_e             state;
  logic [N_CH-1:0]    edge_pulse;
  logic [CNT_W-1:0]   live_cnt  [N_CH];
  logic [CNT_W-1:0]   latch_cnt [N_CH];
  logic [GATE_W-1:0]  gate_reg;
  logic [GATE_W-1:0]  gate_shift;
  logic [GATE_W-1:0]  gate_tmr;
  logic [GB_W-1:0]    gate_byte_idx;
  logic [SEL_W-1:0]   ch_idx;
  logic [BI_W-1:0]    byte_idx;
  logic [BI_W-1:0]    byte_rev;
  logic               hdr_phase;
  logic               cnt_valid;
  logic [CNT_W-1:0]   sel_word;
  logic [7:0]         payload_byte;

  logic rx_start, rx_abort, rx_gate;
  assign rx_start = i_Rx_DV && (i_Rx_Byte == CMD_START);
  assign rx_abort = i_Rx_DV && (i_Rx_Byte == CMD_ABORT);
  assign rx_gate  = i_Rx_DV && (i_Rx_Byte == CMD_GATE);

  for (genvar c = 0; c < N_CH; c++) begin : g_sync
    thr_edge_sync u_sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_Thr   (i_Thr[c]),
      .o_Pulse (edge_pulse[c])
    );
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state         <= ST_IDLE;
      gate_reg      <= GATE_W'(DEFAULT_GATE);
      gate_shift    <= '0;
      gate_byte_idx <= '0;
      gate_tmr      <= '0;
      cnt_valid     <= 1'b0;
      ch_idx        <= '0;
      byte_idx      <= '0;
      hdr_phase     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_start) begin
            state <= ST_ARM;
          end else if (rx_gate) begin
            state         <= ST_LOAD_GATE;
            gate_byte_idx <= '0;
          end
        end
        ST_LOAD_GATE: begin
          // The gate register only changes once the full word has arrived.
          if (rx_abort) begin
            state <= ST_IDLE;
          end else if (i_Rx_DV) begin
            gate_shift <= GATE_W'({gate_shift, i_Rx_Byte});
            if (gate_byte_idx == GB_W'(GB - 1)) begin
              gate_reg <= GATE_W'({gate_shift, i_Rx_Byte});
              state    <= ST_IDLE;
            end else begin
              gate_byte_idx <= gate_byte_idx + 1'b1;
            end
          end
        end
        ST_ARM: begin
          gate_tmr <= (gate_reg == '0) ? GATE_W'(1) : gate_reg;
          state    <= ST_COUNT;
        end
        ST_COUNT: begin
          if (rx_abort)                     state <= ST_IDLE;
          else if (gate_tmr == GATE_W'(1))  state <= ST_LATCH;
          else                              gate_tmr <= gate_tmr - 1'b1;
        end
        ST_LATCH: begin
          cnt_valid <= 1'b1;
          hdr_phase <= 1'b1;
          ch_idx    <= '0;
          byte_idx  <= '0;
          state     <= ST_SEND;
        end
        ST_SEND: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (i_Tx_Done) begin
            state <= ST_SEND;
            if (hdr_phase) begin
              hdr_phase <= 1'b0;
            end else if (byte_idx == BI_W'(NB - 1)) begin
              byte_idx <= '0;
              if (ch_idx == SEL_W'(N_CH - 1)) state  <= ST_IDLE;
              else                            ch_idx <= ch_idx + 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        live_cnt[c]  <= '0;
        latch_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (state == ST_ARM)
          live_cnt[c] <= '0;
        else if ((state == ST_COUNT) && edge_pulse[c] && (live_cnt[c] != '1))
          live_cnt[c] <= live_cnt[c] + 1'b1;
        if (state == ST_LATCH)
          latch_cnt[c] <= live_cnt[c];
      end
    end
  end

  always_comb begin
    sel_word     = latch_cnt[ch_idx];
    byte_rev     = BI_W'(NB - 1) - byte_idx;
    payload_byte = 8'(sel_word >> {byte_rev, 3'b000});
    o_Tx_Byte    = 8'h00;
    if (state == ST_SEND)
      o_Tx_Byte = hdr_phase ? FRAME_HDR : payload_byte;
  end

  always_comb begin
    o_Disp_Cnt = '0;
    for (int c = 0; c < N_CH; c++)
      if (i_Disp_Sel == SEL_W'(c)) o_Disp_Cnt = latch_cnt[c];
  end

  assign o_Tx_DV     = (state == ST_SEND);
  assign o_Busy      = (state != ST_IDLE);
  assign o_Cnt_Valid = cnt_valid;

endmodule

// File: tb/tb_thr_scan_multi.sv
// Directed + randomized bench for thr_scan_multi against an edge-counting frame model.
`timescale 1ns/1ps
module tb_thr_scan_multi;

  logic clk;
  logic rst_n;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  thr_a;
  logic        rx_dv_a;
  logic [7:0]  rx_byte_a;
  logic        tx_dv_a;
  logic [7:0]  tx_byte_a;
  logic        tx_done_a;
  logic [1:0]  sel_a;
  logic [31:0] disp_a;
  logic        busy_a, valid_a;

  logic [3:0]  thr_b;
  logic        rx_dv_b;
  logic [7:0]  rx_byte_b;
  logic        tx_dv_b;
  logic [7:0]  tx_byte_b;
  logic        tx_done_b;
  logic [1:0]  sel_b;
  logic [7:0]  disp_b;
  logic        busy_b, valid_b;

  thr_scan_multi #(.N_CH(4), .CNT_W(32), .GATE_W(32), .DEFAULT_GATE(300)) dut_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Thr(thr_a), .i_Rx_DV(rx_dv_a), .i_Rx_Byte(rx_byte_a),
    .o_Tx_DV(tx_dv_a), .o_Tx_Byte(tx_byte_a), .i_Tx_Done(tx_done_a), .i_Disp_Sel(sel_a),
    .o_Disp_Cnt(disp_a), .o_Busy(busy_a), .o_Cnt_Valid(valid_a)
  );

  thr_scan_multi #(.N_CH(4), .CNT_W(8), .GATE_W(16), .DEFAULT_GATE(1000)) dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Thr(thr_b), .i_Rx_DV(rx_dv_b), .i_Rx_Byte(rx_byte_b),
    .o_Tx_DV(tx_dv_b), .o_Tx_Byte(tx_byte_b), .i_Tx_Done(tx_done_b), .i_Disp_Sel(sel_b),
    .o_Disp_Cnt(disp_b), .o_Busy(busy_b), .o_Cnt_Valid(valid_b)
  );

  int checks = 0;
  int failures = 0;

  byte unsigned rx_q[$];
  byte unsigned rx_q_b[$];
  byte unsigned exp_q[$];
  int dv_cyc[$];
  int done_cyc[$];
  int done_dly = 1;
  int dly_cnt = 0;
  int exp_cnt[4];
  int s_cyc;
  int last_rx_cyc;
  int gate_g;
  logic b_seen = 1'b0;

  // Transmitter model for A: captures bytes and answers with i_Tx_Done after done_dly cycles.
  initial begin
    tx_done_a = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_a = 1'b0;
      if (!rst_n) begin
        dly_cnt = 0;
      end else if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) begin
          tx_done_a = 1'b1;
          done_cyc.push_back(cyc);
        end
      end else if (tx_dv_a) begin
        rx_q.push_back(tx_byte_a);
        dv_cyc.push_back(cyc);
        dly_cnt = done_dly;
      end
    end
  end

  initial begin
    tx_done_b = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_b = b_seen;
      b_seen    = tx_dv_b;
      if (tx_dv_b) rx_q_b.push_back(tx_byte_b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    @(negedge clk);
    rx_dv_a = 1'b1; rx_byte_a = b; last_rx_cyc = cyc;
    @(negedge clk);
    rx_dv_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    rx_dv_b = 1'b1; rx_byte_b = b;
    @(negedge clk);
    rx_dv_b = 1'b0;
  endtask

  task automatic load_gate_a(input logic [31:0] g);
    send_a(8'h47);
    for (int i = 3; i >= 0; i--) send_a(g[8*i +: 8]);
    gate_g = int'(g);
  endtask

  task automatic start_a();
    rx_q.delete(); dv_cyc.delete(); done_cyc.delete();
    send_a(8'h53);
    s_cyc = last_rx_cyc;
  endtask

  task automatic wait_idle_a(input int max, input string tag);
    int n = 0;
    while (busy_a && n < max) begin @(negedge clk); n++; end
    chk(tag, busy_a, 1'b0);
  endtask

  task automatic clear_exp();
    for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
  endtask

  task automatic check_frame(input string tag);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int c = 0; c < 4; c++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(exp_cnt[c] >> (8*b)));
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic check_lat(input string tag, input int g);
    int eff = (g == 0) ? 1 : g;
    chk(tag, (dv_cyc.size() > 0) ? dv_cyc[0] - s_cyc : -1, eff + 3);
  endtask

  task automatic check_disp_a(input string tag);
    for (int c = 0; c < 4; c++) begin
      sel_a = 2'(c);
      #1;
      chk($sformatf("%s_disp%0d", tag, c), disp_a, exp_cnt[c]);
    end
  endtask

  task automatic rand_pulses(input int steps);
    logic [3:0] r;
    for (int s = 0; s < steps; s++) begin
      r = 4'($urandom_range(0, 15));
      @(negedge clk);
      thr_a = r;
      for (int c = 0; c < 4; c++) if (r[c]) exp_cnt[c]++;
      @(negedge clk);
      thr_a = 4'h0;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    thr_a = '0; rx_dv_a = 1'b0; rx_byte_a = '0; sel_a = '0;
    thr_b = '0; rx_dv_b = 1'b0; rx_byte_b = '0; sel_b = 2'd1;
    repeat (3) @(negedge clk);
    chk("rst_tx_dv", tx_dv_a, 1'b0);
    chk("rst_tx_byte", tx_byte_a, 8'h00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_disp", disp_a, 32'h0);
    chk("rst_disp_b", disp_b, 8'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed scan: 10 edges on ch0, 3 on ch2, ch3 held high throughout.
    clear_exp();
    load_gate_a(32'd100);
    chk("gate_load_idle", busy_a, 1'b0);
    thr_a[3] = 1'b1;
    repeat (4) @(negedge clk);
    start_a();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      thr_a[0] = 1'b1;
      if (i < 3) thr_a[2] = 1'b1;
      @(negedge clk);
      thr_a[0] = 1'b0; thr_a[2] = 1'b0;
    end
    exp_cnt[0] = 10; exp_cnt[2] = 3;
    wait_idle_a(400, "t1_idle");
    thr_a[3] = 1'b0;
    check_frame("t1");
    check_lat("t1_lat", 100);
    chk("t1_valid", valid_a, 1'b1);
    check_disp_a("t1");

    // Zero gate behaves as a one-cycle window; live counters must be cleared by ARM.
    clear_exp();
    load_gate_a(32'd0);
    start_a();
    wait_idle_a(100, "g0_idle");
    check_frame("g0");
    check_lat("g0_lat", 0);

    for (int k = 0; k < 3; k++) begin
      clear_exp();
      load_gate_a(32'($urandom_range(60, 150)));
      done_dly = $urandom_range(1, 3);
      start_a();
      repeat (2) @(negedge clk);
      rand_pulses((gate_g - 12) / 2);
      wait_idle_a(gate_g + 200, $sformatf("rnd%0d_idle", k));
      check_frame($sformatf("rnd%0d", k));
      check_lat($sformatf("rnd%0d_lat", k), gate_g);
      check_disp_a($sformatf("rnd%0d", k));
    end
    done_dly = 1;

    // Abort mid-COUNT: results of the previous scan must persist.
    load_gate_a(32'd200);
    start_a();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) thr_a[1] = 1'b1;
      @(negedge clk) thr_a[1] = 1'b0;
    end
    send_a(8'h41);
    repeat (3) @(negedge clk);
    chk("abort_busy", busy_a, 1'b0);
    repeat (250) @(negedge clk);
    chk("abort_no_tx", rx_q.size(), 0);
    chk("abort_valid", valid_a, 1'b1);
    check_disp_a("abort");

    // Abort during gate load leaves the gate at 200.
    send_a(8'h47); send_a(8'h00); send_a(8'h00); send_a(8'h41);
    chk("gabort_busy", busy_a, 1'b0);
    clear_exp();
    start_a();
    wait_idle_a(400, "gabort_idle");
    check_lat("gabort_lat", 200);
    check_frame("gabort");

    // Slow transmitter; 'S' and 'A' during the frame must be ignored.
    clear_exp();
    load_gate_a(32'd40);
    done_dly = 100;
    start_a();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) thr_a[2] = 1'b1;
      @(negedge clk) thr_a[2] = 1'b0;
    end
    exp_cnt[2] = 4;
    n = 0;
    while (rx_q.size() < 2 && n < 1000) begin @(negedge clk); n++; end
    send_a(8'h53);
    send_a(8'h41);
    wait_idle_a(2500, "slow_idle");
    done_dly = 1;
    check_frame("slow");
    check_lat("slow_lat", 40);
    for (int i = 1; i < 17; i++)
      if (i < dv_cyc.size() && i <= done_cyc.size())
        chk($sformatf("slow_gap%0d", i), dv_cyc[i] - done_cyc[i-1], 1);
    repeat (5) @(negedge clk);
    chk("slow_no_restart", busy_a, 1'b0);

    // 8-bit counters saturate: 300 edges on ch1, 7 on ch0.
    rx_q_b.delete();
    send_b(8'h53);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      thr_b[1] = 1'b1;
      if (i < 7) thr_b[0] = 1'b1;
      @(negedge clk);
      thr_b = 4'h0;
    end
    n = 0;
    while (busy_b && n < 1500) begin @(negedge clk); n++; end
    chk("sat_idle", busy_b, 1'b0);
    chk("sat_valid", valid_b, 1'b1);
    sel_b = 2'd1; #1 chk("sat_disp1", disp_b, 8'hFF);
    sel_b = 2'd0; #1 chk("sat_disp0", disp_b, 8'd7);
    sel_b = 2'd3; #1 chk("sat_disp3", disp_b, 8'd0);
    chk("sat_len", rx_q_b.size(), 5);
    if (rx_q_b.size() == 5) begin
      chk("sat_hdr", rx_q_b[0], 8'hA5);
      chk("sat_ch0", rx_q_b[1], 8'd7);
      chk("sat_ch1", rx_q_b[2], 8'hFF);
    end

    // Reset in the middle of a frame.
    clear_exp();
    load_gate_a(32'd30);
    done_dly = 100;
    start_a();
    n = 0;
    while (rx_q.size() < 3 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mrst_tx_dv", tx_dv_a, 1'b0);
    chk("mrst_tx_byte", tx_byte_a, 8'h00);
    chk("mrst_busy", busy_a, 1'b0);
    chk("mrst_valid", valid_a, 1'b0);
    check_disp_a("mrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_dly = 1;
    repeat (300) @(negedge clk);
    chk("mrst_no_more_tx", rx_q.size(), 3);
    start_a();
    wait_idle_a(500, "dflt_idle");
    check_lat("dflt_lat", 300);
    check_frame("dflt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thr_scan_multi.md
# thr_scan_multi

Multi-channel threshold-scan counter. It counts rising edges on N_CH discriminator inputs over a programmable gate window and latches the results. It then streams them out byte-wise through the existing UART transmitter handshake. It sits between `uart_rx`/`tx` and the display path, and replaces the single-channel free-running counter with a gated, command-driven measurement.

## Interface
Parameters:
- N_CH, 4, number of threshold input channels (1..16)
- CNT_W, 32, per-channel counter width; multiple of 8
- GATE_W, 32, gate-length register width; multiple of 8
- DEFAULT_GATE, 50_000_000, gate length in clocks after reset

Ports:
- i_Clock  in  1  system clock; single clock domain
- i_Rst_n  in  1  reset; asynchronous, active-low
- i_Thr  in  N_CH  asynchronous discriminator inputs
- i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte valid
- i_Rx_Byte  in  8  received command/data byte
- o_Tx_DV  out  1  one-cycle strobe: o_Tx_Byte valid, start transmission
- o_Tx_Byte  out  8  byte to transmit
- i_Tx_Done  in  1  one-cycle strobe from transmitter: byte finished
- i_Disp_Sel  in  $clog2(N_CH) (min 1)  channel selected for display
- o_Disp_Cnt  out  CNT_W  latched count of channel i_Disp_Sel
- o_Busy  out  1  high in every state except IDLE
- o_Cnt_Valid  out  1  high once a completed scan has been latched

## Operation
- Each channel uses a 2-FF synchronizer followed by a rising-edge detector, producing a one-cycle pulse per edge.
- Commands are accepted on i_Rx_DV only. All other byte values are ignored.
  - 0x53 'S': start a scan. Accepted only in IDLE.
  - 0x41 'A': abort. Honoured in LOAD_GATE and COUNT.
  - 0x47 'G': load the gate length. Accepted only in IDLE. The next GATE_W/8 bytes are taken MSB-first.
- FSM states and transitions:
  - IDLE: on 'S' → ARM. On 'G' → LOAD_GATE.
  - LOAD_GATE: shifts in bytes. After the last byte, the gate register is updated → IDLE. On 'A', returns to IDLE and the gate register is unchanged.
  - ARM: one cycle. Clears all live counters and loads the gate down-counter → COUNT.
  - COUNT: exactly G cycles, with G=0 treated as 1. An edge pulse that occurs in a COUNT cycle increments its channel's counter. Counters saturate at all-ones. On 'A' → IDLE: no latch, no transmission, and o_Cnt_Valid is unchanged.
  - LATCH: one cycle. Copies live counters into latched registers, sets o_Cnt_Valid → SEND.
  - SEND: drives o_Tx_DV for one cycle with the current byte → WAIT_DONE.
  - WAIT_DONE: on i_Tx_Done, if more bytes remain → SEND; otherwise → IDLE. All Rx bytes, including 'A', are ignored in SEND and WAIT_DONE.
- Frame format: header 0xA5, then channel 0..N_CH-1. Each channel is CNT_W/8 bytes, MSB first. Total length is 1 + N_CH·CNT_W/8 bytes.
- o_Disp_Cnt is driven combinationally from the latched registers through i_Disp_Sel. An out-of-range select reads 0.

## Timing
- Reset values: o_Tx_DV=0, o_Tx_Byte=0x00, o_Busy=0, o_Cnt_Valid=0, o_Disp_Cnt=0. All counters and latched registers are 0, the gate register is DEFAULT_GATE, and the state is IDLE.
- Reset asserted mid-scan or mid-frame aborts immediately. No further o_Tx_DV is issued.
- Latency from an i_Thr rising edge to the counter increment is 3 clocks (2 sync + 1 edge detect).
- Edges arriving within 3 clocks before COUNT ends may land after the window and are not counted. Edges during ARM are not counted.
- Latency from the 'S' strobe to the first COUNT cycle is 2 clocks. The first o_Tx_DV occurs 2 clocks after the last COUNT cycle.
- The next o_Tx_DV comes exactly 1 clock after i_Tx_Done.
- i_Tx_Done outside WAIT_DONE is ignored.
- An input held high across the scan counts 0 edges. Each channel counts independently when edges occur in the same cycle.

## Structure
- Shared package thr_scan_pkg holds:
  - the opcodes CMD_START/CMD_ABORT/CMD_GATE
  - FRAME_HDR = 8'hA5
  - the state enum
- Sub-module thr_edge_sync, instantiated N_CH times via generate: synchronizer plus edge pulse.
- The top level holds the FSM, gate register and down-counter, counters, latches, and the byte serializer (channel index plus byte index).

## Test plan
- Reset, then send 'G',00,00,00,64 then 'S'. Drive 10 pulses on ch0 and 3 on ch2 inside the window. Expect the frame A5, 00 00 00 0A, 00 00 00 00, 00 00 00 03, 00 00 00 00, with o_Cnt_Valid=1.
- Gate G=0 loaded, then 'S'. Expect COUNT to last 1 cycle and the frame to be emitted with all zero counts.
- Counter saturation with CNT_W=8: drive 300 edges on ch1. Expect the ch1 byte to be FF.
- 'A' mid-COUNT: expect return to IDLE, no o_Tx_DV, and o_Cnt_Valid/o_Disp_Cnt holding the previous scan's values. 'S' and 'A' during SEND are ignored, and the frame completes.
- Delay i_Tx_Done by 100 cycles per byte. Expect o_Tx_DV exactly 1 cycle after each i_Tx_Done and 17 bytes total.
- Assert i_Rst_n low mid-frame: expect all outputs at reset values and the gate register back to DEFAULT_GATE.
